// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared constants and state encoding for the instruction fetch
//          stage (datapath width, halt sentinel word, PC increment, FSM
//          state enum).
// Rev    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  localparam int XLEN = 32;

  // Fetching this word stops the fetch stage instead of forwarding it.
  localparam logic [XLEN-1:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch
// Brief  : Single-entry instruction fetch stage. Drives the PC onto an
//          external combinational instruction memory and registers the
//          returned word into a one-deep output slot with valid/ready
//          handshake. Supports PC redirect (flush), halt-word detection and
//          misaligned / out-of-range PC faults.
// Ports  : clk, rst            - clock, async active-high reset
//          imem_addr/imem_data - instruction memory address (=PC) / word
//          redirect_valid/_pc  - load a new PC, flushing the held slot
//          inst_valid/_ready   - output slot handshake
//          inst_data/inst_pc   - held instruction and its PC
//          halted/fault        - terminal status flags
// Rev    : 1.0  initial release
// ============================================================================
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              IMEM_WORDS = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            halted,
  output logic            fault
);

  // One bit wider than the PC so the limit itself cannot overflow.
  localparam logic [XLEN:0] PC_LIMIT = (XLEN+1)'(IMEM_WORDS * 4);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            halted_q, fault_q;

  logic            slot_free;
  logic            pc_out_of_range;

  assign slot_free       = !valid_q || inst_ready;
  assign pc_out_of_range = {1'b0, pc_q} >= PC_LIMIT;

  // --------------------------------------------------------------------------
  // Next-state logic. Priority inside FETCH: redirect, then range fault,
  // then halt word, then normal capture.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    data_d  = data_q;
    ipc_d   = ipc_q;

    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          // Flush regardless of inst_ready; the held word is stale.
          valid_d = 1'b0;
          if (redirect_pc[1:0] == 2'b00) begin
            pc_d = redirect_pc;
          end else begin
            state_d = FAULT;
          end
        end else if (slot_free) begin
          if (pc_out_of_range) begin
            valid_d = 1'b0;
            state_d = FAULT;
          end else if (imem_data == HALT_WORD) begin
            valid_d = 1'b0;
            state_d = HALTED;
          end else begin
            data_d  = imem_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_STEP;
          end
        end
      end

      HALTED, FAULT: begin
        // Terminal until reset; redirects are ignored.
        valid_d = 1'b0;
      end

      default: begin
        state_d = FETCH;
        valid_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ipc_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ipc_q    <= ipc_d;
      halted_q <= (state_d == HALTED);
      fault_q  <= (state_d == FAULT);
    end
  end

  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign inst_data  = data_q;
  assign inst_pc    = ipc_q;
  assign halted     = halted_q;
  assign fault      = fault_q;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetch
// Brief  : Self-checking bench for instr_fetch. A behavioural model of the
//          fetch stage tracks the expected outputs and is compared on every
//          falling clock edge; directed sequences pin the model with literal
//          expectations, then randomized ready/redirect/reset traffic runs.
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

  localparam int MEM_WORDS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        halted;
  logic        fault;

  logic [31:0] mem [MEM_WORDS];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Memory outside the array returns a non-halt filler word.
  assign imem_data = (imem_addr[31:2] < 30'd16) ? mem[imem_addr[5:2]] : 32'hDEAD_BEEF;

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .halted        (halted),
    .fault         (fault)
  );

  // --------------------------------------------------------------------------
  // Behavioural model. m_mode: 0 running, 1 halted, 2 faulted.
  // --------------------------------------------------------------------------
  logic [31:0] m_pc, m_data, m_ipc;
  logic        m_valid;
  int          m_mode;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc    <= 32'h0;
      m_valid <= 1'b0;
      m_data  <= 32'h0;
      m_ipc   <= 32'h0;
      m_mode  <= 0;
    end else if (m_mode == 0) begin
      if (redirect_valid) begin
        m_valid <= 1'b0;
        if (redirect_pc % 4 == 0) m_pc <= redirect_pc;
        else m_mode <= 2;
      end else if (!m_valid || inst_ready) begin
        if (m_pc >= 32'd64) begin
          m_valid <= 1'b0;
          m_mode  <= 2;
        end else if (mem[m_pc / 4] == 32'hFFFF_FFFF) begin
          m_valid <= 1'b0;
          m_mode  <= 1;
        end else begin
          m_data  <= mem[m_pc / 4];
          m_ipc   <= m_pc;
          m_valid <= 1'b1;
          m_pc    <= m_pc + 32'd4;
        end
      end
    end
  end

  // Compare process: every falling edge, DUT vs model.
  always @(negedge clk) begin
    tests++;
    if (imem_addr !== m_pc || inst_valid !== m_valid ||
        (m_valid && (inst_data !== m_data || inst_pc !== m_ipc)) ||
        halted !== (m_mode == 1) || fault !== (m_mode == 2)) begin
      fails++;
      $display("FAIL model_cmp t=%0t got addr=%h v=%b pc=%h d=%h h=%b f=%b, expected addr=%h v=%b pc=%h d=%h h=%b f=%b",
               $time, imem_addr, inst_valid, inst_pc, inst_data, halted, fault,
               m_pc, m_valid, m_ipc, m_data, m_mode == 1, m_mode == 2);
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_program();
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0000_0013;
    mem[0] = 32'h0031_00B3;
    mem[1] = 32'h0030_8233;
    mem[2] = 32'h4012_02B3;
    mem[3] = 32'h0033_1393;
    mem[4] = 32'h0041_8193;
    mem[5] = 32'h0052_0213;
    mem[6] = 32'h0072_A223;
    mem[7] = 32'hFFFF_FFFF;
  endtask

  // Synchronous-looking reset pulse used between directed scenarios.
  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    load_program();
    #3;
    check("reset_addr",   imem_addr,  32'h0);
    check("reset_valid",  {31'b0, inst_valid}, 32'h0);
    check("reset_data",   inst_data,  32'h0);
    check("reset_flags",  {30'b0, halted, fault}, 32'h0);
    step();
    rst = 1'b0;

    // Straight-line fetch
    step();
    check("seq0_pc",   inst_pc,   32'h0);
    check("seq0_data", inst_data, 32'h0031_00B3);
    step();
    check("seq1_pc",   inst_pc,   32'h4);
    check("seq1_data", inst_data, 32'h0030_8233);

    // Backpressure on pc 4 for 3 cycles
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_data", inst_data, 32'h0030_8233);
      check("bp_addr", imem_addr, 32'h8);
    end
    inst_ready = 1'b1;
    step();
    check("seq2_pc",   inst_pc,   32'h8);
    check("seq2_data", inst_data, 32'h4012_02B3);

    // Run on to the halt word at pc 28
    repeat (4) step();
    check("last_pc",   inst_pc,   32'd24);
    check("last_data", inst_data, 32'h0072_A223);
    step();
    check("halt_flag",  {31'b0, halted},     32'h1);
    check("halt_valid", {31'b0, inst_valid}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    redirect_valid = 1'b0;
    check("halt_ignore_redirect", imem_addr, 32'd28);
    check("halt_sticky", {31'b0, halted}, 32'h1);

    // Async reset between edges, then redirect flush under backpressure
    #3 rst = 1'b1;
    #1;
    check("async_addr",  imem_addr, 32'h0);
    check("async_halt",  {31'b0, halted}, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("post_reset_pc", inst_pc, 32'h0);
    step();
    check("flush_pre_pc", inst_pc, 32'h4);
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'd12;
    step();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    check("flush_valid", {31'b0, inst_valid}, 32'h0);
    step();
    check("flush_pc",   inst_pc,   32'd12);
    check("flush_data", inst_data, 32'h0033_1393);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
    step();
    redirect_valid = 1'b0;
    check("misalign_fault", {31'b0, fault},      32'h1);
    check("misalign_valid", {31'b0, inst_valid}, 32'h0);

    // Out-of-range redirect faults on the next accept
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'd64;
    step();
    redirect_valid = 1'b0;
    check("range_addr",  imem_addr, 32'd64);
    check("range_nofault", {31'b0, fault}, 32'h0);
    step();
    check("range_fault", {31'b0, fault}, 32'h1);

    // Redirect wins over a simultaneous halt word
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'd28;
    step();
    redirect_pc    = 32'd0;
    step();
    redirect_valid = 1'b0;
    check("redir_over_halt_flag", {31'b0, halted}, 32'h0);
    check("redir_over_halt_addr", imem_addr, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (m_mode != 0 && $urandom_range(0, 3) == 0 || $urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        for (int i = 0; i < MEM_WORDS; i++)
          mem[i] = ($urandom_range(0, 24) == 0) ? 32'hFFFF_FFFF : $urandom;
        step();
        rst = 1'b0;
      end
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 9))
        0:       redirect_pc = 32'd64 + 32'($urandom_range(0, 7)) * 4;
        1:       redirect_pc = 32'($urandom_range(0, 63)) | 32'h1;
        default: redirect_pc = 32'($urandom_range(0, 15)) * 4;
      endcase
      step();
    end
    redirect_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_instr_fetch
`default_nettype wire
